// File: rtl/channel_pkg.sv
// Shared types and constants for the byte-stream DMA: FSM states, AXI response
// codes and the byte-lane geometry of the 64-bit memory word.
package channel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        RD_SERVE,
        WR_FILL,
        WR_AW_W,
        WR_B,
        DONE
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int BYTE_LANES = 8;
    localparam int LANE_W     = $clog2(BYTE_LANES);

endpackage

// File: rtl/byte_lane_buffer.sv
// One 64-bit memory word with per-byte strobes: whole-word load from memory,
// single-byte insert from the stream, byte lane readout, and clear.
module byte_lane_buffer
    import channel_pkg::*;
(
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    clear,
    input  logic                    load_word,
    input  logic [8*BYTE_LANES-1:0] word_in,
    input  logic                    put_byte,
    input  logic [LANE_W-1:0]       put_lane,
    input  logic [7:0]              put_data,
    input  logic [LANE_W-1:0]       get_lane,
    output logic [7:0]              get_data,
    output logic [8*BYTE_LANES-1:0] word,
    output logic [BYTE_LANES-1:0]   strb
);

    // Clearing the data as well as the strobes keeps unstrobed wdata lanes at zero.
    always_ff @(posedge aclk) begin
        if (!aresetn || clear) begin
            word <= '0;
            strb <= '0;
        end else if (load_word) begin
            word <= word_in;
            strb <= '0;
        end else if (put_byte) begin
            word[{put_lane, 3'b000} +: 8] <= put_data;
            strb[put_lane]                <= 1'b1;
        end
    end

    assign get_data = word[{get_lane, 3'b000} +: 8];

endmodule

// File: rtl/axi_byte_stream_dma.sv
// Byte-granular mover between byte streams and memory over a 64-bit AXI4-Lite
// style master, issuing at most one single-beat transaction per aligned word.
module axi_byte_stream_dma
    import channel_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [COUNT_WIDTH-1:0]  count,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic [7:0]              in_tdata,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    output logic [7:0]              out_tdata,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [63:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [63:0]             m_axi_wdata,
    output logic [7:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [ADDR_WIDTH-1:0]  axi_addr;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   err_flag;

    logic [LANE_W-1:0]      lane;
    logic [ADDR_WIDTH-1:0]  next_addr;
    logic [COUNT_WIDTH-1:0] remaining_dec;
    logic                   last_byte;
    logic                   lane_last;
    logic                   buf_clear;
    logic                   buf_load;
    logic                   buf_put;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
    endfunction

    assign lane          = cur_addr[LANE_W-1:0];
    assign next_addr     = cur_addr + ADDR_WIDTH'(1);
    assign remaining_dec = (remaining != '0) ? remaining - COUNT_WIDTH'(1) : remaining;
    assign last_byte     = (remaining == COUNT_WIDTH'(1));
    assign lane_last     = (lane == LANE_W'(BYTE_LANES - 1));

    assign m_axi_araddr  = axi_addr;
    assign m_axi_awaddr  = axi_addr;

    always_comb begin
        buf_clear = 1'b0;
        buf_load  = 1'b0;
        buf_put   = 1'b0;
        case (state)
            IDLE:    buf_clear = start && !done;
            RD_R:    buf_load  = m_axi_rvalid && (m_axi_rresp == AXI_RESP_OKAY);
            WR_FILL: buf_put   = in_tvalid;
            WR_B:    buf_clear = m_axi_bvalid && (m_axi_bresp == AXI_RESP_OKAY) && (remaining != '0);
            default: ;
        endcase
    end

    byte_lane_buffer u_buf (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear     (buf_clear),
        .load_word (buf_load),
        .word_in   (m_axi_rdata),
        .put_byte  (buf_put),
        .put_lane  (lane),
        .put_data  (in_tdata),
        .get_lane  (lane),
        .get_data  (out_tdata),
        .word      (m_axi_wdata),
        .strb      (m_axi_wstrb)
    );

    // A high done marks the completion cycle, so start is not accepted then.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            cur_addr      <= '0;
            axi_addr      <= '0;
            remaining     <= '0;
            err_flag      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            in_tready     <= 1'b0;
            out_tvalid    <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    if (start && !done) begin
                        cur_addr  <= addr;
                        remaining <= count;
                        err_flag  <= 1'b0;
                        busy      <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                        end else if (write) begin
                            in_tready <= 1'b1;
                            state     <= WR_FILL;
                        end else begin
                            axi_addr      <= word_align(addr);
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_AR;
                        end
                    end
                end
                RD_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        if (m_axi_rresp != AXI_RESP_OKAY) begin
                            err_flag <= 1'b1;
                            state    <= DONE;
                        end else begin
                            out_tvalid <= 1'b1;
                            state      <= RD_SERVE;
                        end
                    end
                end
                RD_SERVE: begin
                    if (out_tready) begin
                        cur_addr  <= next_addr;
                        remaining <= remaining_dec;
                        if (last_byte) begin
                            out_tvalid <= 1'b0;
                            state      <= DONE;
                        end else if (lane_last) begin
                            out_tvalid    <= 1'b0;
                            axi_addr      <= word_align(next_addr);
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_AR;
                        end
                    end
                end
                WR_FILL: begin
                    if (in_tvalid) begin
                        cur_addr  <= next_addr;
                        remaining <= remaining_dec;
                        if (last_byte || lane_last) begin
                            in_tready     <= 1'b0;
                            axi_addr      <= word_align(cur_addr);
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_AW_W;
                        end
                    end
                end
                WR_AW_W: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if ((m_axi_awready || !m_axi_awvalid) && (m_axi_wready || !m_axi_wvalid)) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != AXI_RESP_OKAY) begin
                            err_flag <= 1'b1;
                            state    <= DONE;
                        end else if (remaining == '0) begin
                            state <= DONE;
                        end else begin
                            in_tready <= 1'b1;
                            state     <= WR_FILL;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    error <= err_flag;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_byte_stream_dma.sv
// Directed bench for axi_byte_stream_dma with small AXI slave, stream source
// and stream sink models driven on the falling clock edge.
module tb_axi_byte_stream_dma;
    import channel_pkg::*;

    localparam int AW = 32;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          aresetn, start, write;
    logic [AW-1:0] addr;
    logic [CW-1:0] count;
    logic          busy, done, error;
    logic [7:0]    in_tdata;
    logic          in_tvalid, in_tready;
    logic [7:0]    out_tdata;
    logic          out_tvalid, out_tready;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, arready, rvalid, rready;
    logic [63:0]   rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [7:0]    wstrb;

    always #5 aclk = ~aclk;

    axi_byte_stream_dma #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .write(write), .addr(addr), .count(count),
        .busy(busy), .done(done), .error(error),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory image: byte at b = 0x11*(lane+1) + 8*b[7:3]
    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(17 * (i + 1)) + {a[7:3], 3'b000};
        return w;
    endfunction

    // controls owned by the main sequence
    bit         rresp_err = 1'b0;
    int         aw_hold   = 0;
    logic [7:0] in_bytes[$];
    int         stall_req = 0;
    int         stall_at  = 0;
    logic [7:0] stall_exp = 8'h00;

    // read slave
    logic          ar_f = 1'b0, r_f = 1'b0;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] ar_log[$];
    initial begin
        arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = AXI_RESP_OKAY; r_addr = '0;
        forever begin
            @(negedge aclk);
            if (r_f) begin rvalid = 1'b0; r_f = 1'b0; end
            if (ar_f) begin
                rvalid = 1'b1;
                rdata  = mem_word(r_addr);
                rresp  = rresp_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                ar_f   = 1'b0;
            end
            if (arvalid && arready) begin ar_f = 1'b1; r_addr = araddr; ar_log.push_back(araddr); end
            if (rvalid && rready) r_f = 1'b1;
        end
    end

    // write slave
    logic          aw_f = 1'b0, w_f = 1'b0, aw_ok = 1'b0, w_ok = 1'b0, b_f = 1'b0, aw_active = 1'b0;
    int            aw_wait = 0;
    logic [AW-1:0] aw_log[$];
    logic [63:0]   wd_log[$];
    logic [7:0]    ws_log[$];
    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = AXI_RESP_OKAY;
        forever begin
            @(negedge aclk);
            if (b_f) begin bvalid = 1'b0; b_f = 1'b0; end
            if (aw_f) begin aw_ok = 1'b1; aw_f = 1'b0; aw_active = 1'b0; end
            if (w_f) begin w_ok = 1'b1; w_f = 1'b0; end
            if (aw_ok && w_ok) begin bvalid = 1'b1; aw_ok = 1'b0; w_ok = 1'b0; end
            if (awvalid && !aw_active) begin aw_active = 1'b1; aw_wait = aw_hold; end
            awready = awvalid && (aw_wait == 0);
            if (awvalid && aw_wait > 0) aw_wait--;
            wready = wvalid;
            if (awvalid && awready) begin aw_f = 1'b1; aw_log.push_back(awaddr); end
            if (wvalid && wready) begin w_f = 1'b1; wd_log.push_back(wdata); ws_log.push_back(wstrb); end
            if (bvalid && bready) b_f = 1'b1;
        end
    end

    // stream source
    int   in_idx = 0;
    logic in_f   = 1'b0;
    initial begin
        in_tvalid = 1'b0; in_tdata = '0;
        forever begin
            @(negedge aclk);
            if (in_f) begin in_idx++; in_f = 1'b0; end
            in_tvalid = (in_idx < in_bytes.size());
            in_tdata  = in_tvalid ? in_bytes[in_idx] : 8'h00;
            in_f      = in_tvalid && in_tready;
        end
    end

    // stream sink with one-shot stall request
    logic [7:0] out_log[$];
    int         stall_cnt  = 0;
    int         stall_seen = 0;
    initial begin
        out_tready = 1'b1;
        forever begin
            @(negedge aclk);
            if (stall_req != stall_seen && out_log.size() == stall_at) begin
                stall_cnt  = 5;
                stall_seen = stall_req;
            end
            if (stall_cnt > 0) begin
                out_tready = 1'b0;
                stall_cnt--;
                check_eq("out_hold_valid", 64'(out_tvalid), 64'd1);
                check_eq("out_hold_data", 64'(out_tdata), 64'(stall_exp));
            end else begin
                out_tready = 1'b1;
            end
            if (out_tvalid && out_tready) out_log.push_back(out_tdata);
        end
    end

    // activity monitor
    int done_cnt = 0, arv_cnt = 0, awv_cnt = 0, otv_cnt = 0;
    initial begin
        forever begin
            @(negedge aclk);
            if (done)       done_cnt++;
            if (arvalid)    arv_cnt++;
            if (awvalid)    awv_cnt++;
            if (out_tvalid) otv_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] a, input logic [CW-1:0] c, input logic w);
        start = 1'b1; addr = a; count = c; write = w;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int n = 0;
        while (done_cnt == base && n < 300) begin
            tick();
            n++;
        end
        check_eq({tag, "_timeout"}, {63'd0, done_cnt == base}, 64'd0);
    endtask

    task automatic check_bytes(input string tag, input int base, input int n, input logic [127:0] exp);
        logic [63:0] got;
        check_eq({tag, "_nbytes"}, 64'(out_log.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = (out_log.size() > base + i) ? 64'(out_log[base + i]) : 64'h1FF;
            check_eq($sformatf("%s_byte%0d", tag, i), got, 64'(exp[8*i +: 8]));
        end
    endtask

    function automatic logic [63:0] ar_at(input int idx);
        return (ar_log.size() > idx) ? 64'(ar_log[idx]) : 64'hDEAD_BEEF;
    endfunction

    function automatic logic [9:0] ctrl_outs();
        return {busy, done, error, arvalid, rready, awvalid, wvalid, bready, in_tready, out_tvalid};
    endfunction

    int ab, ob, db, wb, xb, yb, n;

    initial begin
        aresetn = 1'b0; start = 1'b0; write = 1'b0; addr = '0; count = '0;
        repeat (3) tick();
        check_eq("rst_ctrl", 64'(ctrl_outs()), 64'd0);
        check_eq("rst_addr", {araddr, awaddr}, 64'd0);
        check_eq("rst_data", {wdata[55:0], out_tdata}, 64'd0);
        check_eq("rst_wstrb", 64'(wstrb), 64'd0);
        aresetn = 1'b1;
        tick();

        // read, unaligned start inside one word
        ab = ar_log.size(); ob = out_log.size(); db = done_cnt;
        do_start(32'h1005, 16'd3, 1'b0);
        check_eq("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", db);
        check_eq("t1_error", 64'(error), 64'd0);
        check_eq("t1_busy_at_done", 64'(busy), 64'd0);
        check_eq("t1_nar", 64'(ar_log.size() - ab), 64'd1);
        check_eq("t1_araddr", ar_at(ab), 64'h1000);
        check_bytes("t1", ob, 3, 128'h887766);
        tick();
        check_eq("t1_done_pulse", 64'(done), 64'd0);

        // read across a word boundary with sink back-pressure after the first byte
        ab = ar_log.size(); ob = out_log.size(); db = done_cnt;
        stall_at = ob + 1; stall_exp = 8'h88; stall_req++;
        do_start(32'h1006, 16'd4, 1'b0);
        wait_done("t2", db);
        check_eq("t2_error", 64'(error), 64'd0);
        check_eq("t2_nar", 64'(ar_log.size() - ab), 64'd2);
        check_eq("t2_ar0", ar_at(ab), 64'h1000);
        check_eq("t2_ar1", ar_at(ab + 1), 64'h1008);
        check_bytes("t2", ob, 4, 128'h2A198877);
        tick();

        // write three bytes into one word, awready held off after the W beat
        xb = aw_log.size(); wb = ws_log.size(); db = done_cnt; yb = in_idx;
        aw_hold = 3;
        in_bytes.push_back(8'hAA); in_bytes.push_back(8'hBB); in_bytes.push_back(8'hCC);
        do_start(32'h2003, 16'd3, 1'b1);
        n = 0;
        while (ws_log.size() == wb && n < 100) begin tick(); n++; end
        check_eq("t3_w_timeout", {63'd0, ws_log.size() == wb}, 64'd0);
        tick();
        check_eq("t3_wvalid_drop", 64'(wvalid), 64'd0);
        check_eq("t3_awvalid_held", 64'(awvalid), 64'd1);
        wait_done("t3", db);
        check_eq("t3_error", 64'(error), 64'd0);
        check_eq("t3_naw", 64'(aw_log.size() - xb), 64'd1);
        check_eq("t3_awaddr", (aw_log.size() > xb) ? 64'(aw_log[xb]) : 64'hDEAD_BEEF, 64'h2000);
        check_eq("t3_wstrb", (ws_log.size() > wb) ? 64'(ws_log[wb]) : 64'h1FF, 64'h38);
        check_eq("t3_wdata", (wd_log.size() > wb) ? wd_log[wb] : 64'hDEAD_BEEF, 64'h0000_CCBB_AA00_0000);
        check_eq("t3_bytes_taken", 64'(in_idx - yb), 64'd3);
        aw_hold = 0;
        tick();

        // zero-length transfer
        xb = arv_cnt; yb = awv_cnt;
        do_start(32'h1234, 16'd0, 1'b0);
        check_eq("t4_busy", 64'(busy), 64'd1);
        check_eq("t4_done_early", 64'(done), 64'd0);
        tick();
        check_eq("t4_done", 64'(done), 64'd1);
        check_eq("t4_busy_at_done", 64'(busy), 64'd0);
        tick();
        check_eq("t4_no_arvalid", 64'(arv_cnt - xb), 64'd0);
        check_eq("t4_no_awvalid", 64'(awv_cnt - yb), 64'd0);

        // 16-byte read with a stray start while busy
        ab = ar_log.size(); ob = out_log.size(); db = done_cnt; yb = awv_cnt;
        do_start(32'h3000, 16'd16, 1'b0);
        repeat (3) tick();
        do_start(32'h5000, 16'd1, 1'b1);
        wait_done("t5", db);
        check_eq("t5_error", 64'(error), 64'd0);
        check_eq("t5_nar", 64'(ar_log.size() - ab), 64'd2);
        check_eq("t5_ar0", ar_at(ab), 64'h3000);
        check_eq("t5_ar1", ar_at(ab + 1), 64'h3008);
        check_bytes("t5", ob, 16, 128'h907F6E5D4C3B2A198877665544332211);
        repeat (5) tick();
        check_eq("t5_one_done", 64'(done_cnt - db), 64'd1);
        check_eq("t5_idle", 64'(busy), 64'd0);
        check_eq("t5_no_aw", 64'(awv_cnt - yb), 64'd0);

        // read error response on the first beat
        ab = ar_log.size(); db = done_cnt; yb = otv_cnt;
        rresp_err = 1'b1;
        do_start(32'h4000, 16'd8, 1'b0);
        wait_done("t6", db);
        check_eq("t6_error", 64'(error), 64'd1);
        tick();
        check_eq("t6_error_clear", 64'(error), 64'd0);
        check_eq("t6_no_out", 64'(otv_cnt - yb), 64'd0);
        check_eq("t6_nar", 64'(ar_log.size() - ab), 64'd1);
        rresp_err = 1'b0;
        tick();

        // reset while serving bytes
        db = done_cnt;
        do_start(32'h1000, 16'd8, 1'b0);
        n = 0;
        while (!out_tvalid && n < 50) begin tick(); n++; end
        check_eq("t7_serve_timeout", 64'(out_tvalid), 64'd1);
        aresetn = 1'b0;
        tick();
        check_eq("t7_rst_ctrl", 64'(ctrl_outs()), 64'd0);
        check_eq("t7_rst_data", {araddr, 24'd0, out_tdata}, 64'd0);
        aresetn = 1'b1;
        repeat (4) tick();
        check_eq("t7_no_done", 64'(done_cnt - db), 64'd0);

        // new transfer after reset, crossing into the next word from lane 7
        ab = ar_log.size(); ob = out_log.size(); db = done_cnt;
        do_start(32'h100F, 16'd2, 1'b0);
        wait_done("t8", db);
        check_eq("t8_error", 64'(error), 64'd0);
        check_eq("t8_ar0", ar_at(ab), 64'h1008);
        check_eq("t8_ar1", ar_at(ab + 1), 64'h1010);
        check_bytes("t8", ob, 2, 128'h2190);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
